// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply modexp sequencer; all products go to an external Montgomery multiplier.
// One multiplication in flight at a time; the next mm_start follows mm_done by one cycle, and done follows the final product by one cycle.
module mont_modexp_ctrl #(
   parameter int W    = 32,
   parameter int EW   = 32,
   parameter int LENW = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [LENW-1:0] len,
   input  logic [LENW-1:0] e_len,
   input  logic [W-1:0]    base,
   input  logic [EW-1:0]   exp,
   input  logic [W-1:0]    modulus,
   input  logic [W-1:0]    r2_mod,
   output logic            busy,
   output logic            done,
   output logic [W-1:0]    result,
   output logic            mm_start,
   output logic [LENW-1:0] mm_len,
   output logic [W-1:0]    mm_a,
   output logic [W-1:0]    mm_b,
   output logic [W-1:0]    mm_n,
   input  logic            mm_done,
   input  logic [W-1:0]    mm_result
);

   typedef enum logic [3:0] {
      S_IDLE, S_MB_ISSUE, S_MB_WAIT, S_MA_ISSUE, S_MA_WAIT, S_SQ_ISSUE, S_SQ_WAIT,
      S_MUL_ISSUE, S_MUL_WAIT, S_FR_ISSUE, S_FR_WAIT
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    base_r, r2_r, bm, acc;
   logic [EW-1:0]   exp_sh;
   logic [LENW-1:0] bits_left, elen_c;
   logic            accept, cur_bit, last_bit;

   assign elen_c   = (e_len > LENW'(EW)) ? LENW'(EW) : e_len;
   assign accept   = (state == S_IDLE) && start && !done;
   // Exponent is left-aligned at accept so the bit under scan is always the MSB.
   assign cur_bit  = exp_sh[EW-1];
   assign last_bit = (bits_left == LENW'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (accept) state_nxt = S_MB_ISSUE;
         S_MB_ISSUE:  state_nxt = S_MB_WAIT;
         S_MB_WAIT:   if (mm_done) state_nxt = S_MA_ISSUE;
         S_MA_ISSUE:  state_nxt = S_MA_WAIT;
         S_MA_WAIT:   if (mm_done) state_nxt = (bits_left == '0) ? S_FR_ISSUE : S_SQ_ISSUE;
         S_SQ_ISSUE:  state_nxt = S_SQ_WAIT;
         S_SQ_WAIT:   if (mm_done) state_nxt = cur_bit ? S_MUL_ISSUE : (last_bit ? S_FR_ISSUE : S_SQ_ISSUE);
         S_MUL_ISSUE: state_nxt = S_MUL_WAIT;
         S_MUL_WAIT:  if (mm_done) state_nxt = last_bit ? S_FR_ISSUE : S_SQ_ISSUE;
         S_FR_ISSUE:  state_nxt = S_FR_WAIT;
         S_FR_WAIT:   if (mm_done) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      mm_start = 1'b0;
      mm_a     = '0;
      mm_b     = '0;
      case (state)
         S_MB_ISSUE, S_MB_WAIT: begin
            mm_a = base_r;  mm_b = r2_r;
         end
         S_MA_ISSUE, S_MA_WAIT: begin
            mm_a = W'(1);   mm_b = r2_r;
         end
         S_SQ_ISSUE, S_SQ_WAIT: begin
            mm_a = acc;     mm_b = acc;
         end
         S_MUL_ISSUE, S_MUL_WAIT: begin
            mm_a = acc;     mm_b = bm;
         end
         S_FR_ISSUE, S_FR_WAIT: begin
            mm_a = acc;     mm_b = W'(1);
         end
         default: ;
      endcase
      mm_start = (state == S_MB_ISSUE) || (state == S_MA_ISSUE) || (state == S_SQ_ISSUE) ||
                 (state == S_MUL_ISSUE) || (state == S_FR_ISSUE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mm_len    <= '0;
         mm_n      <= '0;
         base_r    <= '0;
         r2_r      <= '0;
         bm        <= '0;
         acc       <= '0;
         exp_sh    <= '0;
         bits_left <= '0;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state == S_FR_WAIT) && mm_done;
         if (accept) begin
            mm_len    <= len;
            mm_n      <= modulus;
            base_r    <= base;
            r2_r      <= r2_mod;
            bits_left <= elen_c;
            exp_sh    <= exp << (EW - int'(elen_c));
         end
         if (mm_done) begin
            case (state)
               S_MB_WAIT: bm  <= mm_result;
               S_MA_WAIT: acc <= mm_result;
               S_SQ_WAIT: begin
                  acc <= mm_result;
                  if (!cur_bit) begin
                     bits_left <= bits_left - LENW'(1);
                     exp_sh    <= exp_sh << 1;
                  end
               end
               S_MUL_WAIT: begin
                  acc       <= mm_result;
                  bits_left <= bits_left - LENW'(1);
                  exp_sh    <= exp_sh << 1;
               end
               S_FR_WAIT: result <= mm_result;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: behavioural Montgomery multiplier with random latency and a result/pulse-count scoreboard.
module tb_mont_modexp_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0, e_len = '0;
   logic [31:0] base = '0, exp_v = '0, modulus = '0, r2_mod = '0;
   logic        busy, done, mm_start, mm_done;
   logic [31:0] result, mm_a, mm_b, mm_n, mm_result;
   logic [7:0]  mm_len;

   logic        model_done = 1'b0, spur_done = 1'b0, spur_issue_en = 1'b0;
   logic [31:0] model_res = '0;
   int          pulse_cnt = 0, stab_bad = 0;
   int          errs = 0, checks = 0;

   typedef struct {
      logic [31:0] res;
      int          pulses;
      int          base_cnt;
   } exp_t;
   exp_t sb_q[$];

   assign mm_done   = model_done | spur_done;
   assign mm_result = spur_done ? 32'hDEAD_BEEF : model_res;

   always #5 clk = ~clk;

   mont_modexp_ctrl #(.W(32), .EW(32), .LENW(8)) dut (
      .clk(clk), .rstn(rstn), .start(start), .len(len), .e_len(e_len), .base(base),
      .exp(exp_v), .modulus(modulus), .r2_mod(r2_mod), .busy(busy), .done(done),
      .result(result), .mm_start(mm_start), .mm_len(mm_len), .mm_a(mm_a), .mm_b(mm_b),
      .mm_n(mm_n), .mm_done(mm_done), .mm_result(mm_result)
   );

   function automatic logic [31:0] mm_f(logic [31:0] a, logic [31:0] b, logic [31:0] n, logic [7:0] l);
      logic [127:0] t;
      t = 128'(a) * 128'(b);
      for (int i = 0; i < int'(l); i++) begin
         if (t[0]) t = t + 128'(n);
         t = t >> 1;
      end
      if (t >= 128'(n)) t = t - 128'(n);
      return t[31:0];
   endfunction

   function automatic logic [31:0] ref_pow(logic [31:0] b, logic [31:0] e, int el, logic [31:0] n);
      logic [63:0] acc;
      acc = 64'(1) % 64'(n);
      for (int i = el - 1; i >= 0; i--) begin
         acc = (acc * acc) % 64'(n);
         if (e[i]) acc = (acc * 64'(b)) % 64'(n);
      end
      return acc[31:0];
   endfunction

   function automatic logic [31:0] r2_of(logic [31:0] n, int l);
      logic [63:0] r;
      r = 64'(1) % 64'(n);
      for (int i = 0; i < 2 * l; i++) r = (r << 1) % 64'(n);
      return r[31:0];
   endfunction

   function automatic int popcnt(logic [31:0] e, int el);
      logic [31:0] m;
      m = (el >= 32) ? 32'hFFFF_FFFF : ((32'(1) << el) - 32'(1));
      return $countones(e & m);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
   endtask

   // Multiplier model: one job at a time, aborts on reset, flags operand motion during the wait.
   initial begin
      logic [31:0] a, b, n;
      logic [7:0]  l;
      int          lat;
      bit          aborted;
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (rstn && mm_start) begin
            pulse_cnt++;
            a = mm_a; b = mm_b; n = mm_n; l = mm_len;
            lat = $urandom_range(40, 1);
            aborted = 1'b0;
            if (spur_issue_en) begin
               model_done = 1'b1;
               model_res  = 32'hDEAD_BEEF;
            end
            for (int k = 0; k < lat; k++) begin
               @(negedge clk);
               model_done = 1'b0;
               if (!rstn) begin
                  aborted = 1'b1;
                  break;
               end
               if (mm_a !== a || mm_b !== b || mm_start !== 1'b0) stab_bad++;
            end
            if (!aborted) begin
               model_done = 1'b1;
               model_res  = mm_f(a, b, n, l);
            end
         end
      end
   end

   // Drives a request (called at a negedge) and records the expected outcome.
   task automatic issue(input logic [31:0] n, input int l, input int el, input logic [31:0] b, input logic [31:0] e);
      exp_t x;
      int   elc;
      elc = (el > 32) ? 32 : el;
      len = 8'(l); e_len = 8'(el); base = b; exp_v = e; modulus = n; r2_mod = r2_of(n, l);
      start = 1'b1;
      x.res = ref_pow(b, e, elc, n);
      x.pulses = 3 + elc + popcnt(e, elc);
      x.base_cnt = pulse_cnt;
      sb_q.push_back(x);
   endtask

   task automatic wait_done(input int extra_at, input bit chk_hold, input logic [31:0] hold_val);
      bit   seen;
      int   hold_bad;
      exp_t x;
      seen = 1'b0;
      hold_bad = 0;
      for (int cyc = 0; cyc < 6000 && !seen; cyc++) begin
         @(negedge clk);
         if (cyc == extra_at) begin
            start = 1'b1; base = base ^ 32'h5; exp_v = ~exp_v;
         end else if (cyc == extra_at + 1) begin
            start = 1'b0;
         end
         if (done) begin
            seen = 1'b1;
            check("busy_at_done", 32'(busy), 32'(0));
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'(sb_q.size()), 32'(1));
            end else begin
               x = sb_q.pop_front();
               check("result", result, x.res);
               check("mm_starts", 32'(pulse_cnt - x.base_cnt), 32'(x.pulses));
            end
         end else if (chk_hold && result !== hold_val) begin
            hold_bad++;
         end
      end
      check("done_seen", 32'(seen), 32'(1));
      if (chk_hold) check("result_held", 32'(hold_bad), 32'(0));
   endtask

   task automatic run_job(input logic [31:0] n, input int l, input int el, input logic [31:0] b, input logic [31:0] e);
      issue(n, l, el, b, e);
      @(negedge clk);
      start = 1'b0;
      wait_done(-1, 1'b0, '0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'(0));
   endtask

   initial begin
      logic [31:0] held, n;
      int          l, snap;
      #3;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_result", result, 32'(0));
      check("rst_mm_start", 32'(mm_start), 32'(0));
      check("rst_mm_a", mm_a, 32'(0));
      check("rst_mm_n", mm_n, 32'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      run_job(32'd13, 4, 3, 32'd4, 32'd5);

      // Spurious mm_done in every ISSUE cycle and a start while busy.
      spur_issue_en = 1'b1;
      issue(32'd23, 5, 4, 32'd7, 32'd11);
      @(negedge clk);
      start = 1'b0;
      wait_done(5, 1'b0, '0);
      spur_issue_en = 1'b0;
      @(negedge clk);

      run_job(32'd13, 4, 0, 32'd9, 32'hFFFF_FFFF);

      held = result;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      check("idle_spur_busy", 32'(busy), 32'(0));
      check("idle_spur_done", 32'(done), 32'(0));
      check("idle_spur_result", result, held);

      // Reset while the first squaring is outstanding.
      issue(32'd13, 4, 3, 32'd4, 32'd5);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if (pulse_cnt - sb_q[0].base_cnt == 3 && !mm_start) break;
      end
      rstn = 1'b0;
      snap = pulse_cnt;
      #1;
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_done", 32'(done), 32'(0));
      check("arst_result", result, 32'(0));
      check("arst_mm_start", 32'(mm_start), 32'(0));
      check("arst_mm_a", mm_a, 32'(0));
      check("arst_mm_b", mm_b, 32'(0));
      check("arst_mm_n", mm_n, 32'(0));
      check("arst_mm_len", 32'(mm_len), 32'(0));
      void'(sb_q.pop_front());
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_start", 32'(pulse_cnt - snap), 32'(0));
      run_job(32'd13, 4, 3, 32'd4, 32'd5);

      // Back-to-back: start held from the done cycle; only the following cycle may accept it.
      issue(32'd23, 5, 4, 32'd7, 32'd11);
      @(negedge clk);
      start = 1'b0;
      wait_done(-1, 1'b0, '0);
      held = result;
      issue(32'd13, 4, 3, 32'd4, 32'd5);
      @(negedge clk);
      check("b2b_not_in_done", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accepted", 32'(busy), 32'(1));
      wait_done(-1, 1'b1, held);
      @(negedge clk);

      run_job(32'd13, 4, 40, 32'd6, 32'h8000_0005);

      for (int j = 0; j < 4; j++) begin
         l = $urandom_range(31, 4);
         n = ($urandom() % (32'(1) << l)) | 32'(1) | (32'(1) << (l - 1));
         run_job(n, l, $urandom_range(32, 0), $urandom() % n, $urandom());
      end

      check("operands_stable", 32'(stab_bad), 32'(0));
      check("sb_empty", 32'(sb_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
